ahb_slave_interface: RTL and testbench
======================================

AHB_SLAVE_INTERFACE -- requirements
Module: ahb_slave_interface

Interface
REQ-001 SHALL have port Hclk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Hreset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports Hwrite in 1, Hreadyin in 1, Htrans in 2, Haddr in 32, Hwdata in 32: AHB master address/data phase.
REQ-004 SHALL have port Prdata  in  32  read data from APB side.
REQ-005 SHALL have port Hready_apb  in  1  ready from downstream APB controller.
REQ-006 SHALL have port valid  out  1  mapped active transfer present this cycle.
REQ-007 SHALL have ports Haddr1, Haddr2  out  32  address pipeline stages 1 and 2.
REQ-008 SHALL have ports Hwdata1, Hwdata2  out  32  write-data pipeline stages 1 and 2.
REQ-009 SHALL have port Hwritereg  out  1  Hwrite registered one cycle.
REQ-010 SHALL have port tempselx  out  3  one-hot peripheral select decoded from Haddr.
REQ-011 SHALL have ports Hrdata out 32, Hreadyout out 1, Hresp out 2: AHB response to master.
REQ-012 SHALL have port Herr_cnt  out  8  saturating count of ERROR responses.
REQ-013 SHALL have parameter ERR_RESP, default 2'b01, Hresp encoding for ERROR (OKAY = 2'b00).

Function
REQ-014 Decode (combinational): 0x8000_0000-0x83FF_FFFF -> tempselx 3'b001; 0x8400_0000-0x87FF_FFFF -> 3'b010; 0x8800_0000-0x8BFF_FFFF -> 3'b100; otherwise 3'b000 (unmapped); bounds inclusive.
REQ-015 "Active" SHALL mean Hreadyin=1 and Htrans in {2'b10 NONSEQ, 2'b11 SEQ}; IDLE/BUSY never active.
REQ-016 valid SHALL be combinational = active AND mapped AND state OK AND Hreset=0.
REQ-017 On each edge with Hreadyin=1 and Hreset=0: Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1, Hwritereg<=Hwrite; with Hreadyin=0 all five SHALL hold.
REQ-018 Hrdata SHALL be combinational pass-through of Prdata.
REQ-019 FSM states OK, ERR1, ERR2.
REQ-020 OK -> ERR1 when active AND unmapped; else stay OK.
REQ-021 ERR1 -> ERR2 unconditionally; ERR2 -> OK unconditionally.
REQ-022 Outputs per state: OK: Hreadyout=Hready_apb, Hresp=2'b00; ERR1: Hreadyout=0, Hresp=ERR_RESP; ERR2: Hreadyout=1, Hresp=ERR_RESP.
REQ-023 valid SHALL be 0 in ERR1 and ERR2 regardless of inputs; an address presented during ERR2 SHALL be ignored for decode/error purposes (master is expected to drive IDLE).
REQ-024 Herr_cnt SHALL increment by 1 on each OK->ERR1 transition, saturate at 8'hFF, never wrap.
REQ-025 Unmapped access with Hwrite=0 or 1 SHALL be treated identically; Hwdata of an erroring write SHALL still enter the pipeline per REQ-017.
REQ-026 Back-to-back mapped transfers SHALL keep valid=1 each cycle with no inserted bubble from this block.

Reset
REQ-027 While Hreset=1 at an edge: state<=OK, Haddr1/Haddr2/Hwdata1/Hwdata2<=0, Hwritereg<=0, Herr_cnt<=0.
REQ-028 During reset cycles valid SHALL be 0 and Hresp 2'b00; Hreadyout follows Hready_apb.
REQ-029 Reset asserted in ERR1 or ERR2 SHALL return to OK on that edge, abandoning the error response; Herr_cnt cleared.

Verification
REQ-030 Reset, then NONSEQ write Haddr=0x8000_0004, Hreadyin=1 -> valid=1, tempselx=3'b001 same cycle; next edge Haddr1=0x8000_0004, Hwritereg=1.
REQ-031 Three back-to-back SEQ writes at 0x8400_0000/04/08 -> valid high 3 cycles, tempselx=3'b010; after third edge Haddr2=0x8400_0004, Haddr1=0x8400_0008, Hwdata pipeline equally lagged.
REQ-032 NONSEQ read at 0x9000_0000 -> valid=0, next cycle Hreadyout=0 Hresp=01, following cycle Hreadyout=1 Hresp=01, then Hresp=00; Herr_cnt=1.
REQ-033 Hreadyin=0 with Htrans=NONSEQ, Haddr mapped -> valid=0, pipeline registers unchanged.
REQ-034 256+ unmapped accesses -> Herr_cnt=0xFF and holds; Hreset=1 asserted during ERR1 -> next cycle state OK, Hresp=00, Herr_cnt=0.

Source files
------------

// File: rtl/ahb_slave_interface.sv
// rtl/ahb_slave_interface.sv - AHB slave front end: address decode, transfer pipeline and two-cycle ERROR response
module ahb_slave_interface #(
  parameter logic [1:0] ERR_RESP = 2'b01
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  input  logic        Hready_apb,
  output logic        valid,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic [2:0]  tempselx,
  output logic [31:0] Hrdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [7:0]  Herr_cnt
);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ERR1 = 2'b01;
  localparam logic [1:0] ST_ERR2 = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       active;
  logic       mapped;
  logic       err_start;

  // Peripheral select: three 64 MiB windows starting at 0x8000_0000
  always_comb begin
    tempselx = 3'b000;
    if (Haddr >= 32'h8000_0000 && Haddr <= 32'h83FF_FFFF)
      tempselx = 3'b001;
    else if (Haddr >= 32'h8400_0000 && Haddr <= 32'h87FF_FFFF)
      tempselx = 3'b010;
    else if (Haddr >= 32'h8800_0000 && Haddr <= 32'h8BFF_FFFF)
      tempselx = 3'b100;
  end

  assign active    = Hreadyin && (Htrans == 2'b10 || Htrans == 2'b11);
  assign mapped    = |tempselx;
  // Addresses seen while an error response is in flight are ignored
  assign err_start = (state == ST_OK) && active && !mapped;
  assign valid     = active && mapped && (state == ST_OK) && !Hreset;
  assign Hrdata    = Prdata;

  // Error response sequencing: one wait beat, one final beat, back to OK
  always_comb begin
    state_nxt = ST_OK;
    case (state)
      ST_OK:   state_nxt = err_start ? ST_ERR1 : ST_OK;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = ST_OK;
      default: state_nxt = ST_OK;
    endcase
  end

  // State register and saturating error counter
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state    <= ST_OK;
      Herr_cnt <= 8'h00;
    end else begin
      state <= state_nxt;
      if (err_start && Herr_cnt != 8'hFF)
        Herr_cnt <= Herr_cnt + 8'h01;
    end
  end

  // Address/data pipeline advances only when the bus is ready, errors included
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Haddr1    <= 32'h0;
      Haddr2    <= 32'h0;
      Hwdata1   <= 32'h0;
      Hwdata2   <= 32'h0;
      Hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

  // Response to the master; reset forces an OKAY pass-through
  always_comb begin
    Hreadyout = Hready_apb;
    Hresp     = 2'b00;
    if (!Hreset) begin
      case (state)
        ST_ERR1: begin
          Hreadyout = 1'b0;
          Hresp     = ERR_RESP;
        end
        ST_ERR2: begin
          Hreadyout = 1'b1;
          Hresp     = ERR_RESP;
        end
        default: begin
          Hreadyout = Hready_apb;
          Hresp     = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_interface.sv
// tb/tb_ahb_slave_interface.sv - randomized self-checking bench for ahb_slave_interface
module tb_ahb_slave_interface;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b0;
  logic [1:0]  Htrans = 2'b00;
  logic [31:0] Haddr = 32'h0;
  logic [31:0] Hwdata = 32'h0;
  logic [31:0] Prdata = 32'h0;
  logic        Hready_apb = 1'b1;
  logic        valid;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
  logic        Hwritereg;
  logic [2:0]  tempselx;
  logic [31:0] Hrdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [7:0]  Herr_cnt;

  ahb_slave_interface #(.ERR_RESP(2'b01)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .Hready_apb(Hready_apb), .valid(valid), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Hwritereg(Hwritereg),
    .tempselx(tempselx), .Hrdata(Hrdata), .Hreadyout(Hreadyout),
    .Hresp(Hresp), .Herr_cnt(Herr_cnt)
  );

  always #5 Hclk = ~Hclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pipeline contents, error count, and a queue of pending
  // error response beats (each entry is the Hreadyout value of that beat)
  logic [31:0] m_a1 = 0, m_a2 = 0, m_d1 = 0, m_d2 = 0;
  logic        m_wr = 0;
  int          m_cnt = 0;
  bit          m_err_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    logic [31:0] off;
    int idx;
    if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
    off = a - 32'h8000_0000;
    idx = int'(off / 32'h0400_0000);
    return 3'(1 << idx);
  endfunction

  task automatic cycle(input logic rst, input logic wr, input logic rdyin,
                       input logic [1:0] tr, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdyapb);
    logic act;
    logic [2:0] sel;
    @(negedge Hclk);
    Hreset = rst; Hwrite = wr; Hreadyin = rdyin; Htrans = tr; Haddr = a;
    Hwdata = wd; Prdata = $urandom; Hready_apb = rdyapb;
    #1;
    act = rdyin && (tr == 2'b10 || tr == 2'b11);
    sel = exp_sel(a);
    chk("tempselx", {29'h0, tempselx}, {29'h0, sel});
    chk("Hrdata", Hrdata, Prdata);
    if (rst || m_err_q.size() == 0) begin
      chk("Hresp", {30'h0, Hresp}, 32'h0);
      chk("Hreadyout", {31'h0, Hreadyout}, {31'h0, rdyapb});
      chk("valid", {31'h0, valid}, {31'h0, !rst && act && sel != 0});
    end else begin
      chk("Hresp_err", {30'h0, Hresp}, 32'h1);
      chk("Hreadyout_err", {31'h0, Hreadyout}, {31'h0, m_err_q[0]});
      chk("valid_err", {31'h0, valid}, 32'h0);
    end
    @(posedge Hclk);
    if (rst) begin
      m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_wr = 0; m_cnt = 0;
      m_err_q.delete();
    end else begin
      if (m_err_q.size() != 0) void'(m_err_q.pop_front());
      else if (act && sel == 0) begin
        m_err_q.push_back(1'b0);
        m_err_q.push_back(1'b1);
        if (m_cnt < 255) m_cnt++;
      end
      if (rdyin) begin
        m_a2 = m_a1; m_a1 = a; m_d2 = m_d1; m_d1 = wd; m_wr = wr;
      end
    end
    #1;
    chk("Haddr1", Haddr1, m_a1);
    chk("Haddr2", Haddr2, m_a2);
    chk("Hwdata1", Hwdata1, m_d1);
    chk("Hwdata2", Hwdata2, m_d2);
    chk("Hwritereg", {31'h0, Hwritereg}, {31'h0, m_wr});
    chk("Herr_cnt", {24'h0, Herr_cnt}, 32'(m_cnt));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 11))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h83FF_FFFF;
      3: return 32'h8400_0000;
      4: return 32'h87FF_FFFF;
      5: return 32'h8800_0000;
      6: return 32'h8BFF_FFFF;
      7: return 32'h8C00_0000;
      8: return $urandom;
      default: return 32'h8000_0000 + 32'($urandom_range(0, 32'h0BFF_FFFF));
    endcase
  endfunction

  initial begin
    cycle(1, 0, 0, 2'b00, 32'h0, 32'h0, 1);
    cycle(1, 1, 1, 2'b10, 32'h8000_0000, 32'h1234, 0);
    // Single mapped write
    cycle(0, 1, 1, 2'b10, 32'h8000_0004, 32'hA5A5_0001, 1);
    cycle(0, 0, 1, 2'b00, 32'h0, 32'h0, 1);
    // Back-to-back sequential writes in the second window
    cycle(0, 1, 1, 2'b10, 32'h8400_0000, 32'h1111_0000, 1);
    cycle(0, 1, 1, 2'b11, 32'h8400_0004, 32'h1111_0004, 1);
    cycle(0, 1, 1, 2'b11, 32'h8400_0008, 32'h1111_0008, 1);
    // Unmapped read followed by idle
    cycle(0, 0, 1, 2'b10, 32'h9000_0000, 32'h0, 1);
    cycle(0, 0, 1, 2'b00, 32'h0, 32'h0, 1);
    cycle(0, 0, 1, 2'b00, 32'h0, 32'h0, 1);
    cycle(0, 0, 1, 2'b00, 32'h0, 32'h0, 1);
    // Hreadyin low holds the pipeline and suppresses valid
    cycle(0, 1, 0, 2'b10, 32'h8800_0000, 32'hDEAD_BEEF, 1);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 60) == 0), 1'($urandom), ($urandom_range(0, 4) != 0),
            2'($urandom), rand_addr(), $urandom, 1'($urandom));
    // Saturation of the error counter
    cycle(1, 0, 0, 2'b00, 32'h0, 32'h0, 1);
    for (int i = 0; i < 800; i++)
      cycle(0, 1'($urandom), 1, 2'b10, 32'hC000_0000, $urandom, 1);
    chk("Herr_cnt_sat", {24'h0, Herr_cnt}, 32'h0000_00FF);
    for (int i = 0; i < 6; i++)
      cycle(0, 0, 1, 2'b10, 32'h0000_1000, 32'h0, 1);
    chk("Herr_cnt_hold", {24'h0, Herr_cnt}, 32'h0000_00FF);
    // Reset while in the wait beat of an error response
    cycle(0, 0, 1, 2'b00, 32'h0, 32'h0, 1);
    cycle(0, 0, 1, 2'b00, 32'h0, 32'h0, 1);
    cycle(0, 0, 1, 2'b00, 32'h0, 32'h0, 1);
    cycle(0, 0, 1, 2'b10, 32'hF000_0000, 32'h0, 1);
    cycle(1, 0, 1, 2'b00, 32'h0, 32'h0, 0);
    cycle(0, 0, 1, 2'b00, 32'h0, 32'h0, 1);
    chk("Herr_cnt_after_rst", {24'h0, Herr_cnt}, 32'h0);
    chk("Hresp_after_rst", {30'h0, Hresp}, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
